pipeline_decode: RTL and testbench
==================================

# pipeline_decode

Decode stage of the 5-stage MIPS pipeline. It sits directly downstream of the fetch stage and consumes its `pc_out`, `inst_out` and `br_late_done_d1`. It returns two combinational feedback signals to fetch: the early-branch command and the load-stall request. It also drives register-file read addresses and a registered decoded bundle into the ALU/execute stage.

## Interface
- No parameters.
- `clk  in  1  clock`
- `rst  in  1  reset, synchronous, active-high`
- `pc_in  in  32  PC from fetch`
- `inst_in  in  32  instruction from fetch; 0 = nop/bubble`
- `br_late_done_d1  in  1  marks inst_in as the first correct-path instruction after a late redirect`
- `br_late_enable  in  1  late branch taken, from ALU stage`
- `early_branch_cmd  out  4  combinational; command to the fetch predictor`
- `memread_enable  out  1  combinational; one-cycle pulse per decoded load`
- `rf_raddr_a, rf_raddr_b  out  5 each  combinational; rs / rt of inst_in`
- `ex_valid  out  1  bundle valid`
- `ex_pc, ex_inst  out  32 each`
- `ex_alu_op  out  4`
- `ex_imm  out  32`
- `ex_use_imm  out  1`
- `ex_dst  out  5`
- `ex_reg_write  out  1`
- `ex_mem_read, ex_mem_write  out  1 each`
- `ex_mem_size  out  2  0=byte, 1=half, 2=word`
- `ex_mem_unsigned  out  1`
- `ex_link  out  1  write pc+8`
- `ex_branch_cond  out  3  0=none, 1=BEQ, 2=BNE, 3=BLEZ, 4=BGTZ, 5=BLTZ, 6=BGEZ, 7=JR`
- `illegal_inst  out  1  registered, one-cycle pulse`

## Operation
- **State machine.** Two states, RUN and SQUASH; reset enters RUN.
  - RUN→SQUASH on `br_late_enable`.
  - SQUASH→RUN on `br_late_done_d1 & !br_late_enable`. The instruction presented that cycle is decoded normally.
  - `br_late_enable` has priority over everything else. It stays in SQUASH, or enters it, and squashes the current `inst_in`.
- **Squash.** The current instruction is squashed when the state is SQUASH and `br_late_done_d1=0`, or when `br_late_enable=1`. A squashed instruction produces the following:
  - `ex_valid=0` next cycle.
  - `early_branch_cmd=0` and `memread_enable=0` this cycle.
  - There are no delay-slot semantics: every younger instruction is discarded.
- **Bubbles.** `inst_in==0` is a bubble. It gives `ex_valid=0`, all control outputs 0, and no feedback.
- **Early branch command**, for non-squashed, non-bubble instructions:
  - 4'b0001 for J/JAL.
  - 4'b0010 for BEQ/BNE/BLEZ/BGTZ/REGIMM BLTZ/BGEZ.
  - 4'b0100 for JR/JALR.
  - Otherwise 0.
- **Load stall.** `memread_enable=1` for LB/LBU/LH/LHU/LW. Fetch then supplies three nop cycles, which decode passes through as bubbles. Decode never re-asserts during those cycles.
- **Immediates.**
  - Sign-extended for ADDI/ADDIU/SLTI/SLTIU/loads/stores/branches.
  - Zero-extended for ANDI/ORI/XORI.
  - For LUI, {imm16,16'b0}.
  - For J/JAL, {pc_in[31:28],inst[25:0],2'b00}.
- **ALU op encoding:** 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 LUI, 12 PASS. Variable shifts use the same codes with `ex_use_imm=0`. Loads and stores use ADD.
- **Destination register.**
  - R-type writes rd.
  - I-type writes rt.
  - JAL writes 31 with `ex_link=1` and `ex_alu_op=PASS`.
  - JALR writes rd with `ex_link=1`.
  - Stores, branches, J and JR have `ex_reg_write=0`.
  - Any write with destination 0 forces `ex_reg_write=0`.
- **Illegal opcode/funct.** Gives `ex_valid=0` and a one-cycle `illegal_inst=1` on the following cycle.

## Timing
- `early_branch_cmd`, `memread_enable` and `rf_raddr_*` are purely combinational from `inst_in`, state and `br_late_enable`, with zero latency.
- The `ex_*` bundle and `illegal_inst` are registered, with one-cycle latency.
- **Reset values:** state RUN, all `ex_*` 0, `illegal_inst` 0. Combinational outputs follow their inputs; they are 0 when `inst_in=0`.
- Reset mid-operation abandons SQUASH and clears the bundle on the next edge.
- There is no back-pressure. Every cycle either accepts one instruction or produces one bubble.

## Test plan
- **Reset.** Assert rst for 2 cycles with `inst_in=0x8C220004` → all `ex_*`=0. After release, `memread_enable=1` combinationally.
- **ADDIU.** Decode 0x2422FFFF (addiu $2,$1,-1) → next cycle:
  - `ex_valid=1`, `ex_alu_op=0`, `ex_imm=0xFFFFFFFF`, `ex_use_imm=1`, `ex_dst=2`, `ex_reg_write=1`.
  - `rf_raddr_a=1`.
- **Load stall.** Present LW 0x8C220004, then three zeros → `memread_enable` high only in the LW cycle. The LW bundle has `ex_mem_read=1` and `ex_mem_size=2`, followed by three `ex_valid=0` cycles.
- **JAL.** JAL 0x0C000010 at `pc_in=0x40000000` → `early_branch_cmd=0001`. Next cycle `ex_imm=0x40000040`, `ex_dst=31`, `ex_link=1`.
- **Late redirect.** Pulse `br_late_enable`, then present two instructions with `br_late_done_d1=0`, then ORI with `br_late_done_d1=1`:
  - Three `ex_valid=0` cycles, then ORI valid.
  - `early_branch_cmd` and `memread_enable` stay 0 on the squashed loads/jumps.
- **Simultaneous events and write to $0.**
  - `br_late_done_d1=1` together with `br_late_enable=1` → the instruction is squashed and the state stays SQUASH.
  - ADDU with rd=0 → `ex_reg_write=0`, `ex_valid=1`.

Source files
------------

// File: rtl/pipeline_decode_if.sv
// pipeline_decode_if
// Bundles the decode stage's fetch-side inputs, feedback outputs and the
// registered execute bundle into one interface.
//   master : driven by fetch / ALU side (pc_in, inst_in, br_late_*)
//   slave  : the decode stage (drives feedback, rf read addresses, ex_*)
interface pipeline_decode_if;
   logic [31:0] pc_in;
   logic [31:0] inst_in;
   logic        br_late_done_d1;
   logic        br_late_enable;

   logic [3:0]  early_branch_cmd;
   logic        memread_enable;
   logic [4:0]  rf_raddr_a;
   logic [4:0]  rf_raddr_b;

   logic        ex_valid;
   logic [31:0] ex_pc;
   logic [31:0] ex_inst;
   logic [3:0]  ex_alu_op;
   logic [31:0] ex_imm;
   logic        ex_use_imm;
   logic [4:0]  ex_dst;
   logic        ex_reg_write;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic [1:0]  ex_mem_size;
   logic        ex_mem_unsigned;
   logic        ex_link;
   logic [2:0]  ex_branch_cond;
   logic        illegal_inst;

   modport master (
      output pc_in, inst_in, br_late_done_d1, br_late_enable,
      input  early_branch_cmd, memread_enable, rf_raddr_a, rf_raddr_b,
      input  ex_valid, ex_pc, ex_inst, ex_alu_op, ex_imm, ex_use_imm, ex_dst,
      input  ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_size,
      input  ex_mem_unsigned, ex_link, ex_branch_cond, illegal_inst
   );

   modport slave (
      input  pc_in, inst_in, br_late_done_d1, br_late_enable,
      output early_branch_cmd, memread_enable, rf_raddr_a, rf_raddr_b,
      output ex_valid, ex_pc, ex_inst, ex_alu_op, ex_imm, ex_use_imm, ex_dst,
      output ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_size,
      output ex_mem_unsigned, ex_link, ex_branch_cond, illegal_inst
   );
endinterface

// File: rtl/pipeline_decode.sv
// pipeline_decode
// MIPS decode stage. Decodes inst_in, returns early-branch and load-stall
// feedback to fetch combinationally, drives rf read addresses, and registers
// a decoded bundle for execute. Squashes wrong-path instructions after a late
// branch redirect.
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   dec  : pipeline_decode_if.slave (fetch inputs, feedback, ex_* bundle)
//
// state     | meaning
// ST_RUN    | normal decode
// ST_SQUASH | late redirect in flight; discard until br_late_done_d1
module pipeline_decode (
   input logic              clk,
   input logic              rst,
   pipeline_decode_if.slave dec
);
   localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3,  OP_XOR = 4'd4,  OP_NOR = 4'd5;
   localparam logic [3:0] OP_SLT = 4'd6,  OP_SLTU = 4'd7, OP_SLL = 4'd8;
   localparam logic [3:0] OP_SRL = 4'd9,  OP_SRA = 4'd10, OP_LUI = 4'd11;
   localparam logic [3:0] OP_PASS = 4'd12;

   typedef enum logic {ST_RUN, ST_SQUASH} state_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] inst;
      logic [3:0]  alu_op;
      logic [31:0] imm;
      logic        use_imm;
      logic [4:0]  dst;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic [1:0]  mem_size;
      logic        mem_unsigned;
      logic        link;
      logic [2:0]  branch_cond;
   } ex_bundle_t;

   state_t     state_q, state_d;
   ex_bundle_t bundle_q, bundle_d, dcd;
   logic       illegal_q, illegal_d;
   logic       squash, legal, is_load, bubble, illegal;
   logic [3:0] ebc;

   logic [31:0] inst;
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [31:0] imm_sext, imm_zext;

   assign inst     = dec.inst_in;
   assign op       = inst[31:26];
   assign rs       = inst[25:21];
   assign rt       = inst[20:16];
   assign rd       = inst[15:11];
   assign shamt    = inst[10:6];
   assign funct    = inst[5:0];
   assign imm_sext = {{16{inst[15]}}, inst[15:0]};
   assign imm_zext = {16'd0, inst[15:0]};

   // br_late_enable wins over a coincident done marker.
   assign squash = dec.br_late_enable | ((state_q == ST_SQUASH) & ~dec.br_late_done_d1);

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_RUN;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (dec.br_late_enable)
         state_d = ST_SQUASH;
      else if ((state_q == ST_SQUASH) && dec.br_late_done_d1)
         state_d = ST_RUN;
   end

   always_comb begin
      dcd         = '0;
      dcd.valid   = 1'b1;
      dcd.pc      = dec.pc_in;
      dcd.inst    = inst;
      legal       = 1'b1;
      is_load     = 1'b0;
      ebc         = 4'd0;
      case (op)
         6'h00: begin
            dcd.dst       = rd;
            dcd.reg_write = 1'b1;
            dcd.imm       = {27'd0, shamt};
            case (funct)
               6'h00: begin dcd.alu_op = OP_SLL; dcd.use_imm = 1'b1; end
               6'h02: begin dcd.alu_op = OP_SRL; dcd.use_imm = 1'b1; end
               6'h03: begin dcd.alu_op = OP_SRA; dcd.use_imm = 1'b1; end
               6'h04: dcd.alu_op = OP_SLL;
               6'h06: dcd.alu_op = OP_SRL;
               6'h07: dcd.alu_op = OP_SRA;
               6'h08: begin
                  dcd.alu_op = OP_PASS; dcd.reg_write = 1'b0;
                  dcd.branch_cond = 3'd7; ebc = 4'b0100;
               end
               6'h09: begin
                  dcd.alu_op = OP_PASS; dcd.link = 1'b1;
                  dcd.branch_cond = 3'd7; ebc = 4'b0100;
               end
               6'h20, 6'h21: dcd.alu_op = OP_ADD;
               6'h22, 6'h23: dcd.alu_op = OP_SUB;
               6'h24: dcd.alu_op = OP_AND;
               6'h25: dcd.alu_op = OP_OR;
               6'h26: dcd.alu_op = OP_XOR;
               6'h27: dcd.alu_op = OP_NOR;
               6'h2A: dcd.alu_op = OP_SLT;
               6'h2B: dcd.alu_op = OP_SLTU;
               default: legal = 1'b0;
            endcase
         end
         6'h01: begin
            dcd.alu_op = OP_SUB; dcd.imm = imm_sext; ebc = 4'b0010;
            if (rt == 5'd0)      dcd.branch_cond = 3'd5;
            else if (rt == 5'd1) dcd.branch_cond = 3'd6;
            else                 legal = 1'b0;
         end
         6'h02, 6'h03: begin
            dcd.alu_op = OP_PASS;
            dcd.imm    = {dec.pc_in[31:28], inst[25:0], 2'b00};
            ebc        = 4'b0001;
            if (op[0]) begin
               dcd.dst = 5'd31; dcd.reg_write = 1'b1; dcd.link = 1'b1;
            end
         end
         // BEQ..BGTZ are opcodes 4..7, branch_cond 1..4.
         6'h04, 6'h05, 6'h06, 6'h07: begin
            dcd.alu_op = OP_SUB; dcd.imm = imm_sext; ebc = 4'b0010;
            dcd.branch_cond = op[2:0] - 3'd3;
         end
         6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
            dcd.dst = rt; dcd.reg_write = 1'b1; dcd.use_imm = 1'b1;
            dcd.imm = imm_sext;
            case (op[2:0])
               3'd0, 3'd1: dcd.alu_op = OP_ADD;
               3'd2:       dcd.alu_op = OP_SLT;
               3'd3:       dcd.alu_op = OP_SLTU;
               3'd4: begin dcd.alu_op = OP_AND; dcd.imm = imm_zext; end
               3'd5: begin dcd.alu_op = OP_OR;  dcd.imm = imm_zext; end
               3'd6: begin dcd.alu_op = OP_XOR; dcd.imm = imm_zext; end
               default: begin dcd.alu_op = OP_LUI; dcd.imm = {inst[15:0], 16'd0}; end
            endcase
         end
         6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
            dcd.alu_op = OP_ADD; dcd.imm = imm_sext; dcd.use_imm = 1'b1;
            dcd.dst = rt; dcd.reg_write = 1'b1; dcd.mem_read = 1'b1;
            dcd.mem_unsigned = op[2];
            dcd.mem_size = (op[1:0] == 2'b11) ? 2'd2 : {1'b0, op[0]};
            is_load = 1'b1;
         end
         6'h28, 6'h29, 6'h2B: begin
            dcd.alu_op = OP_ADD; dcd.imm = imm_sext; dcd.use_imm = 1'b1;
            dcd.mem_write = 1'b1;
            dcd.mem_size = (op[1:0] == 2'b11) ? 2'd2 : {1'b0, op[0]};
         end
         default: legal = 1'b0;
      endcase
      if (dcd.dst == 5'd0) dcd.reg_write = 1'b0;
   end

   // An all-zero word is a bubble, not SLL $0,$0,0.
   assign bubble  = (inst == 32'd0);
   assign illegal = ~bubble & ~legal & ~squash;

   always_comb begin
      bundle_d  = '0;
      illegal_d = illegal;
      if (~bubble && legal && ~squash) bundle_d = dcd;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bundle_q  <= '0;
         illegal_q <= 1'b0;
      end else begin
         bundle_q  <= bundle_d;
         illegal_q <= illegal_d;
      end
   end

   assign dec.early_branch_cmd = (~bubble && legal && ~squash) ? ebc : 4'd0;
   assign dec.memread_enable   = ~bubble & legal & ~squash & is_load;
   assign dec.rf_raddr_a       = rs;
   assign dec.rf_raddr_b       = rt;

   assign dec.ex_valid        = bundle_q.valid;
   assign dec.ex_pc           = bundle_q.pc;
   assign dec.ex_inst         = bundle_q.inst;
   assign dec.ex_alu_op       = bundle_q.alu_op;
   assign dec.ex_imm          = bundle_q.imm;
   assign dec.ex_use_imm      = bundle_q.use_imm;
   assign dec.ex_dst          = bundle_q.dst;
   assign dec.ex_reg_write    = bundle_q.reg_write;
   assign dec.ex_mem_read     = bundle_q.mem_read;
   assign dec.ex_mem_write    = bundle_q.mem_write;
   assign dec.ex_mem_size     = bundle_q.mem_size;
   assign dec.ex_mem_unsigned = bundle_q.mem_unsigned;
   assign dec.ex_link         = bundle_q.link;
   assign dec.ex_branch_cond  = bundle_q.branch_cond;
   assign dec.illegal_inst    = illegal_q;
endmodule

// File: tb/tb_pipeline_decode.sv
module tb_pipeline_decode;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   pipeline_decode_if dif();

   pipeline_decode u_dut (
      .clk (clk),
      .rst (rst),
      .dec (dif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      dif.inst_in = 32'h8C220004;
      tick();
      tick();
      total++; if (dif.ex_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h exp=0", dif.ex_valid); end
      total++; if (dif.ex_mem_read !== 1'b0) begin bad++; $display("FAIL rst_mem_read got=%0h exp=0", dif.ex_mem_read); end
      total++; if (dif.ex_inst !== 32'd0) begin bad++; $display("FAIL rst_inst got=%0h exp=0", dif.ex_inst); end
      total++; if (dif.illegal_inst !== 1'b0) begin bad++; $display("FAIL rst_illegal got=%0h exp=0", dif.illegal_inst); end
      rst = 1'b0;
      #1;
      total++; if (dif.memread_enable !== 1'b1) begin bad++; $display("FAIL rst_memread got=%0h exp=1", dif.memread_enable); end
      dif.inst_in = 32'd0;
      tick();
   endtask

   task automatic test_addiu();
      dif.inst_in = 32'h2422FFFF;
      #1;
      total++; if (dif.rf_raddr_a !== 5'd1) begin bad++; $display("FAIL addiu_raddr_a got=%0d exp=1", dif.rf_raddr_a); end
      total++; if (dif.rf_raddr_b !== 5'd2) begin bad++; $display("FAIL addiu_raddr_b got=%0d exp=2", dif.rf_raddr_b); end
      total++; if (dif.early_branch_cmd !== 4'd0) begin bad++; $display("FAIL addiu_ebc got=%0h exp=0", dif.early_branch_cmd); end
      tick();
      total++; if (dif.ex_valid !== 1'b1) begin bad++; $display("FAIL addiu_valid got=%0h exp=1", dif.ex_valid); end
      total++; if (dif.ex_alu_op !== 4'd0) begin bad++; $display("FAIL addiu_alu got=%0d exp=0", dif.ex_alu_op); end
      total++; if (dif.ex_imm !== 32'hFFFFFFFF) begin bad++; $display("FAIL addiu_imm got=%0h exp=ffffffff", dif.ex_imm); end
      total++; if (dif.ex_use_imm !== 1'b1) begin bad++; $display("FAIL addiu_use_imm got=%0h exp=1", dif.ex_use_imm); end
      total++; if (dif.ex_dst !== 5'd2) begin bad++; $display("FAIL addiu_dst got=%0d exp=2", dif.ex_dst); end
      total++; if (dif.ex_reg_write !== 1'b1) begin bad++; $display("FAIL addiu_wr got=%0h exp=1", dif.ex_reg_write); end
      total++; if (dif.ex_inst !== 32'h2422FFFF) begin bad++; $display("FAIL addiu_inst got=%0h exp=2422ffff", dif.ex_inst); end
      dif.inst_in = 32'd0;
      tick();
   endtask

   task automatic test_load_stall();
      dif.inst_in = 32'h8C220004;
      #1;
      total++; if (dif.memread_enable !== 1'b1) begin bad++; $display("FAIL lw_memread got=%0h exp=1", dif.memread_enable); end
      tick();
      total++; if (dif.ex_valid !== 1'b1) begin bad++; $display("FAIL lw_valid got=%0h exp=1", dif.ex_valid); end
      total++; if (dif.ex_mem_read !== 1'b1) begin bad++; $display("FAIL lw_mem_read got=%0h exp=1", dif.ex_mem_read); end
      total++; if (dif.ex_mem_size !== 2'd2) begin bad++; $display("FAIL lw_size got=%0d exp=2", dif.ex_mem_size); end
      total++; if (dif.ex_imm !== 32'd4) begin bad++; $display("FAIL lw_imm got=%0h exp=4", dif.ex_imm); end
      total++; if (dif.ex_alu_op !== 4'd0) begin bad++; $display("FAIL lw_alu got=%0d exp=0", dif.ex_alu_op); end
      dif.inst_in = 32'd0;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (dif.memread_enable !== 1'b0) begin bad++; $display("FAIL nop%0d_memread got=%0h exp=0", i, dif.memread_enable); end
         tick();
         total++; if (dif.ex_valid !== 1'b0) begin bad++; $display("FAIL nop%0d_valid got=%0h exp=0", i, dif.ex_valid); end
      end
   endtask

   task automatic test_jal();
      dif.pc_in   = 32'h40000000;
      dif.inst_in = 32'h0C000010;
      #1;
      total++; if (dif.early_branch_cmd !== 4'b0001) begin bad++; $display("FAIL jal_ebc got=%0h exp=1", dif.early_branch_cmd); end
      tick();
      total++; if (dif.ex_imm !== 32'h40000040) begin bad++; $display("FAIL jal_imm got=%0h exp=40000040", dif.ex_imm); end
      total++; if (dif.ex_dst !== 5'd31) begin bad++; $display("FAIL jal_dst got=%0d exp=31", dif.ex_dst); end
      total++; if (dif.ex_link !== 1'b1) begin bad++; $display("FAIL jal_link got=%0h exp=1", dif.ex_link); end
      total++; if (dif.ex_alu_op !== 4'd12) begin bad++; $display("FAIL jal_alu got=%0d exp=12", dif.ex_alu_op); end
      total++; if (dif.ex_reg_write !== 1'b1) begin bad++; $display("FAIL jal_wr got=%0h exp=1", dif.ex_reg_write); end
      total++; if (dif.ex_pc !== 32'h40000000) begin bad++; $display("FAIL jal_pc got=%0h exp=40000000", dif.ex_pc); end
      dif.pc_in   = 32'd0;
      dif.inst_in = 32'd0;
      tick();
   endtask

   task automatic test_branches();
      dif.inst_in = 32'h10220003;
      #1;
      total++; if (dif.early_branch_cmd !== 4'b0010) begin bad++; $display("FAIL beq_ebc got=%0h exp=2", dif.early_branch_cmd); end
      tick();
      total++; if (dif.ex_branch_cond !== 3'd1) begin bad++; $display("FAIL beq_cond got=%0d exp=1", dif.ex_branch_cond); end
      total++; if (dif.ex_reg_write !== 1'b0) begin bad++; $display("FAIL beq_wr got=%0h exp=0", dif.ex_reg_write); end
      total++; if (dif.ex_imm !== 32'd3) begin bad++; $display("FAIL beq_imm got=%0h exp=3", dif.ex_imm); end
      dif.inst_in = 32'h03E00008;
      #1;
      total++; if (dif.early_branch_cmd !== 4'b0100) begin bad++; $display("FAIL jr_ebc got=%0h exp=4", dif.early_branch_cmd); end
      total++; if (dif.rf_raddr_a !== 5'd31) begin bad++; $display("FAIL jr_raddr got=%0d exp=31", dif.rf_raddr_a); end
      tick();
      total++; if (dif.ex_branch_cond !== 3'd7) begin bad++; $display("FAIL jr_cond got=%0d exp=7", dif.ex_branch_cond); end
      total++; if (dif.ex_reg_write !== 1'b0) begin bad++; $display("FAIL jr_wr got=%0h exp=0", dif.ex_reg_write); end
      dif.inst_in = 32'd0;
      tick();
   endtask

   task automatic test_late_redirect();
      dif.br_late_enable = 1'b1;
      dif.inst_in = 32'h10220003;
      #1;
      total++; if (dif.early_branch_cmd !== 4'd0) begin bad++; $display("FAIL sq0_ebc got=%0h exp=0", dif.early_branch_cmd); end
      tick();
      total++; if (dif.ex_valid !== 1'b0) begin bad++; $display("FAIL sq0_valid got=%0h exp=0", dif.ex_valid); end
      dif.br_late_enable  = 1'b0;
      dif.br_late_done_d1 = 1'b0;
      dif.inst_in = 32'h8C220004;
      #1;
      total++; if (dif.memread_enable !== 1'b0) begin bad++; $display("FAIL sq1_memread got=%0h exp=0", dif.memread_enable); end
      tick();
      total++; if (dif.ex_valid !== 1'b0) begin bad++; $display("FAIL sq1_valid got=%0h exp=0", dif.ex_valid); end
      dif.inst_in = 32'h08000004;
      #1;
      total++; if (dif.early_branch_cmd !== 4'd0) begin bad++; $display("FAIL sq2_ebc got=%0h exp=0", dif.early_branch_cmd); end
      tick();
      total++; if (dif.ex_valid !== 1'b0) begin bad++; $display("FAIL sq2_valid got=%0h exp=0", dif.ex_valid); end
      dif.br_late_done_d1 = 1'b1;
      dif.inst_in = 32'h3422ABCD;
      tick();
      total++; if (dif.ex_valid !== 1'b1) begin bad++; $display("FAIL ori_valid got=%0h exp=1", dif.ex_valid); end
      total++; if (dif.ex_alu_op !== 4'd3) begin bad++; $display("FAIL ori_alu got=%0d exp=3", dif.ex_alu_op); end
      total++; if (dif.ex_imm !== 32'h0000ABCD) begin bad++; $display("FAIL ori_imm got=%0h exp=abcd", dif.ex_imm); end
      total++; if (dif.ex_dst !== 5'd2) begin bad++; $display("FAIL ori_dst got=%0d exp=2", dif.ex_dst); end
      dif.br_late_done_d1 = 1'b0;
      dif.inst_in = 32'h8C220004;
      #1;
      total++; if (dif.memread_enable !== 1'b1) begin bad++; $display("FAIL post_run_memread got=%0h exp=1", dif.memread_enable); end
      dif.inst_in = 32'd0;
      tick();
   endtask

   task automatic test_simul_and_r0();
      dif.br_late_enable  = 1'b1;
      dif.br_late_done_d1 = 1'b1;
      dif.inst_in = 32'h8C220004;
      #1;
      total++; if (dif.memread_enable !== 1'b0) begin bad++; $display("FAIL simul_memread got=%0h exp=0", dif.memread_enable); end
      tick();
      total++; if (dif.ex_valid !== 1'b0) begin bad++; $display("FAIL simul_valid got=%0h exp=0", dif.ex_valid); end
      dif.br_late_enable  = 1'b0;
      dif.br_late_done_d1 = 1'b0;
      #1;
      total++; if (dif.memread_enable !== 1'b0) begin bad++; $display("FAIL stay_sq_memread got=%0h exp=0", dif.memread_enable); end
      tick();
      total++; if (dif.ex_valid !== 1'b0) begin bad++; $display("FAIL stay_sq_valid got=%0h exp=0", dif.ex_valid); end
      dif.br_late_done_d1 = 1'b1;
      dif.inst_in = 32'h00220021;
      tick();
      total++; if (dif.ex_valid !== 1'b1) begin bad++; $display("FAIL r0_valid got=%0h exp=1", dif.ex_valid); end
      total++; if (dif.ex_reg_write !== 1'b0) begin bad++; $display("FAIL r0_wr got=%0h exp=0", dif.ex_reg_write); end
      total++; if (dif.ex_alu_op !== 4'd0) begin bad++; $display("FAIL r0_alu got=%0d exp=0", dif.ex_alu_op); end
      dif.br_late_done_d1 = 1'b0;
      dif.inst_in = 32'd0;
      tick();
   endtask

   task automatic test_illegal();
      dif.inst_in = 32'hFC000000;
      #1;
      total++; if (dif.early_branch_cmd !== 4'd0) begin bad++; $display("FAIL ill_ebc got=%0h exp=0", dif.early_branch_cmd); end
      tick();
      total++; if (dif.ex_valid !== 1'b0) begin bad++; $display("FAIL ill_valid got=%0h exp=0", dif.ex_valid); end
      total++; if (dif.illegal_inst !== 1'b1) begin bad++; $display("FAIL ill_pulse got=%0h exp=1", dif.illegal_inst); end
      dif.inst_in = 32'd0;
      tick();
      total++; if (dif.illegal_inst !== 1'b0) begin bad++; $display("FAIL ill_clear got=%0h exp=0", dif.illegal_inst); end
   endtask

   task automatic test_reset_mid_squash();
      dif.br_late_enable = 1'b1;
      tick();
      dif.br_late_enable = 1'b0;
      rst = 1'b1;
      tick();
      total++; if (dif.ex_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%0h exp=0", dif.ex_valid); end
      rst = 1'b0;
      dif.inst_in = 32'h3422ABCD;
      tick();
      total++; if (dif.ex_valid !== 1'b1) begin bad++; $display("FAIL rstmid_run got=%0h exp=1", dif.ex_valid); end
      dif.inst_in = 32'd0;
      tick();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      dif.pc_in           = 32'd0;
      dif.inst_in         = 32'd0;
      dif.br_late_done_d1 = 1'b0;
      dif.br_late_enable  = 1'b0;
      test_reset();
      test_addiu();
      test_load_stall();
      test_jal();
      test_branches();
      test_late_redirect();
      test_simul_and_r0();
      test_illegal();
      test_reset_mid_squash();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
